// File: rtl/apb_gpio_multibank_pkg.sv
// Shared definitions for the multi-bank APB GPIO controller: register map,
// interrupt mode encoding and bank-count helper.
package apb_gpio_multibank_pkg;

    localparam logic [3:0] REG_DIR      = 4'h0;
    localparam logic [3:0] REG_IN       = 4'h1;
    localparam logic [3:0] REG_OUT      = 4'h2;
    localparam logic [3:0] REG_OUTSET   = 4'h3;
    localparam logic [3:0] REG_OUTCLR   = 4'h4;
    localparam logic [3:0] REG_OUTTGL   = 4'h5;
    localparam logic [3:0] REG_INTEN    = 4'h6;
    localparam logic [3:0] REG_INTTYPE0 = 4'h7;
    localparam logic [3:0] REG_INTTYPE1 = 4'h8;
    localparam logic [3:0] REG_INTANY   = 4'h9;
    localparam logic [3:0] REG_INTSTAT  = 4'hA;
    localparam logic [3:0] REG_DBEN     = 4'hB;

    // Word address (PADDR[11:2]) of the global debounce prescaler, byte offset 0xFC0
    localparam logic [9:0] DBPRESC_WADDR = 10'h3F0;

    typedef enum logic [1:0] {
        LEV1 = 2'b00,
        LEV0 = 2'b01,
        RISE = 2'b10,
        FALL = 2'b11
    } int_mode_e;

    function automatic int num_banks(input int n);
        return (n + 31) / 32;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Vectorised per-pin debouncer. With enable low the synchronised level passes
// straight through; with enable high a change is accepted after DB_SAMPLES ticks.
module gpio_debounce #(
    parameter int WIDTH      = 32,
    parameter int DB_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sync_in,
    input  logic [WIDTH-1:0] en,
    input  logic             tick,
    output logic [WIDTH-1:0] level_d,
    output logic [WIDTH-1:0] level_q
);

    localparam int CNT_W = $clog2(DB_SAMPLES + 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // A pin has one possible candidate (the opposite of the accepted level), so the
    // run of matching samples restarts whenever the input falls back to the level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!en[i]) begin
                cnt_d[i]   = '0;
                level_d[i] = sync_in[i];
            end else if (sync_in[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] >= CNT_W'(DB_SAMPLES - 1)) begin
                    cnt_d[i]   = '0;
                    level_d[i] = sync_in[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/apb_gpio_multibank.sv
// APB GPIO controller with 32-bit banks: atomic output updates, sticky W1C
// interrupts with level/edge/any-edge modes, optional debounce, per-bank IRQ.
module apb_gpio_multibank
    import apb_gpio_multibank_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_GPIO       = 64,
    parameter int NUM_SYNC       = 2,
    parameter int DB_SAMPLES     = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
    input  logic [31:0]                   PWDATA,
    input  logic                          PWRITE,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    output logic [31:0]                   PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic [NUM_GPIO-1:0]           gpio_in,
    output logic [NUM_GPIO-1:0]           gpio_out,
    output logic [NUM_GPIO-1:0]           gpio_dir,
    output logic [num_banks(NUM_GPIO)-1:0] interrupt
);

    localparam int NB = num_banks(NUM_GPIO);
    localparam int W  = NB * 32;
    localparam logic [W-1:0] PIN_MASK = {W{1'b1}} >> (W - NUM_GPIO);

    logic [NUM_SYNC-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0] dir_q, dir_d, out_q, out_d, inten_q, inten_d;
    logic [W-1:0] type0_q, type0_d, type1_q, type1_d, any_q, any_d;
    logic [W-1:0] stat_q, stat_d, dben_q, dben_d;
    logic [15:0]  presc_q, presc_d, pcnt_q, pcnt_d;
    logic [NB-1:0] irq_q, irq_d;

    logic [W-1:0] gin_pad, in_q, in_d, rise, fall, cond, w1c;
    logic [31:0]  wd;
    logic         access, wr_en, is_presc, mapped, tick, unused_addr;
    logic [5:0]   bank_idx;
    logic [3:0]   reg_idx;

    assign access   = PSEL & PENABLE;
    assign bank_idx = PADDR[11:6];
    assign reg_idx  = PADDR[5:2];
    assign is_presc = (PADDR[11:2] == DBPRESC_WADDR);
    assign mapped   = is_presc | ((int'(bank_idx) < NB) & (reg_idx <= REG_DBEN));
    assign wr_en    = access & PWRITE & mapped;
    assign PSLVERR  = access & ~mapped;
    assign PREADY   = 1'b1;
    assign unused_addr = ^PADDR;

    assign gin_pad = W'(gpio_in);
    assign tick    = (pcnt_q >= presc_q);
    assign pcnt_d  = tick ? 16'h0 : pcnt_q + 16'h1;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = gin_pad;
        for (int k = 1; k < NUM_SYNC; k++) sync_d[k] = sync_q[k-1];
    end

    gpio_debounce #(.WIDTH(W), .DB_SAMPLES(DB_SAMPLES)) u_debounce (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .sync_in (sync_q[NUM_SYNC-1]),
        .en      (dben_q),
        .tick    (tick),
        .level_d (in_d),
        .level_q (in_q)
    );

    // Edges are judged on the cycle the accepted level changes, so status sets
    // on the same edge that IN updates.
    assign rise = in_d & ~in_q;
    assign fall = ~in_d & in_q;

    always_comb begin
        cond = '0;
        for (int i = 0; i < W; i++) begin
            if (any_q[i]) begin
                cond[i] = rise[i] | fall[i];
            end else begin
                case (int_mode_e'({type1_q[i], type0_q[i]}))
                    LEV1: cond[i] = in_d[i];
                    LEV0: cond[i] = ~in_d[i];
                    RISE: cond[i] = rise[i];
                    FALL: cond[i] = fall[i];
                endcase
            end
        end
    end

    always_comb begin
        dir_d   = dir_q;
        out_d   = out_q;
        inten_d = inten_q;
        type0_d = type0_q;
        type1_d = type1_q;
        any_d   = any_q;
        dben_d  = dben_q;
        presc_d = presc_q;
        w1c     = '0;
        wd      = '0;
        if (wr_en && is_presc) presc_d = PWDATA[15:0];
        for (int b = 0; b < NB; b++) begin
            if (wr_en && !is_presc && int'(bank_idx) == b) begin
                wd = PWDATA & PIN_MASK[b*32 +: 32];
                case (reg_idx)
                    REG_DIR:      dir_d[b*32 +: 32]   = wd;
                    REG_OUT:      out_d[b*32 +: 32]   = wd;
                    REG_OUTSET:   out_d[b*32 +: 32]   = out_q[b*32 +: 32] | wd;
                    REG_OUTCLR:   out_d[b*32 +: 32]   = out_q[b*32 +: 32] & ~wd;
                    REG_OUTTGL:   out_d[b*32 +: 32]   = out_q[b*32 +: 32] ^ wd;
                    REG_INTEN:    inten_d[b*32 +: 32] = wd;
                    REG_INTTYPE0: type0_d[b*32 +: 32] = wd;
                    REG_INTTYPE1: type1_d[b*32 +: 32] = wd;
                    REG_INTANY:   any_d[b*32 +: 32]   = wd;
                    REG_INTSTAT:  w1c[b*32 +: 32]     = wd;
                    REG_DBEN:     dben_d[b*32 +: 32]  = wd;
                    default: ;
                endcase
            end
        end
        // A new event wins over a software clear landing on the same edge
        stat_d = (stat_q & ~w1c) | (inten_q & cond & PIN_MASK);
        for (int b = 0; b < NB; b++) irq_d[b] = |stat_q[b*32 +: 32];
    end

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE && mapped) begin
            if (is_presc) begin
                PRDATA = {16'h0, presc_q};
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (int'(bank_idx) == b) begin
                        case (reg_idx)
                            REG_DIR:      PRDATA = dir_q[b*32 +: 32];
                            REG_IN:       PRDATA = in_q[b*32 +: 32];
                            REG_OUT:      PRDATA = out_q[b*32 +: 32];
                            REG_INTEN:    PRDATA = inten_q[b*32 +: 32];
                            REG_INTTYPE0: PRDATA = type0_q[b*32 +: 32];
                            REG_INTTYPE1: PRDATA = type1_q[b*32 +: 32];
                            REG_INTANY:   PRDATA = any_q[b*32 +: 32];
                            REG_INTSTAT:  PRDATA = stat_q[b*32 +: 32];
                            REG_DBEN:     PRDATA = dben_q[b*32 +: 32];
                            default:      PRDATA = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q  <= '0;
            dir_q   <= '0;
            out_q   <= '0;
            inten_q <= '0;
            type0_q <= '0;
            type1_q <= '0;
            any_q   <= '0;
            stat_q  <= '0;
            dben_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            irq_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            inten_q <= inten_d;
            type0_q <= type0_d;
            type1_q <= type1_d;
            any_q   <= any_d;
            stat_q  <= stat_d;
            dben_q  <= dben_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            irq_q   <= irq_d;
        end
    end

    assign gpio_out  = out_q[NUM_GPIO-1:0];
    assign gpio_dir  = dir_q[NUM_GPIO-1:0];
    assign interrupt = irq_q;

endmodule

// File: tb/tb_apb_gpio_multibank.sv
// Scoreboard bench for apb_gpio_multibank: stimulus pushes expected responses,
// a negedge monitor pops them on each APB access phase or pin probe.
module tb_apb_gpio_multibank;

    localparam int NUM_GPIO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [NUM_GPIO-1:0] gpio_in = '0;
    logic [NUM_GPIO-1:0] gpio_out;
    logic [NUM_GPIO-1:0] gpio_dir;
    logic [1:0]  irq;

    always #5 clk = ~clk;

    apb_gpio_multibank #(
        .APB_ADDR_WIDTH (12),
        .NUM_GPIO       (NUM_GPIO),
        .NUM_SYNC       (2),
        .DB_SAMPLES     (4)
    ) dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PWRITE    (pwrite),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_dir  (gpio_dir),
        .interrupt (irq)
    );

    // kind: 0 = APB access response, 1 = gpio_out, 2 = interrupt, 3 = gpio_dir
    typedef struct {
        int          kind;
        logic [63:0] val;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic probe    = 1'b0;

    always @(negedge clk) begin
        if ((psel && penable) || probe) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL no_expectation: DUT output seen with empty scoreboard");
            end else begin
                mon_e = sb.pop_front();
                if (psel && penable) begin
                    if (mon_e.kind == 0 && prdata === mon_e.val[31:0] &&
                        pslverr === mon_e.err && pready === 1'b1)
                        n_pass++;
                    else
                        $display("FAIL %s: PRDATA=%h PSLVERR=%b PREADY=%b, required PRDATA=%h PSLVERR=%b PREADY=1",
                                 mon_e.name, prdata, pslverr, pready, mon_e.val[31:0], mon_e.err);
                end else begin
                    logic [63:0] act;
                    act = (mon_e.kind == 1) ? gpio_out :
                          (mon_e.kind == 2) ? {62'h0, irq} :
                          (mon_e.kind == 3) ? gpio_dir : 64'hx;
                    if (act === mon_e.val) n_pass++;
                    else $display("FAIL %s: got %h, required %h", mon_e.name, act, mon_e.val);
                end
            end
        end
    end

    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_rd, input logic exp_err, input string name);
        exp_t e;
        e.kind = 0;
        e.val  = {32'h0, wr ? 32'h0 : exp_rd};
        e.err  = exp_err;
        e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        apb(1'b1, addr, data, 32'h0, 1'b0, $sformatf("wr_%h", addr));
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp_rd,
                      input logic exp_err, input string name);
        apb(1'b0, addr, 32'h0, exp_rd, exp_err, name);
    endtask

    task automatic probe_pins(input int kind, input logic [63:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.err  = 1'b0;
        e.name = name;
        sb.push_back(e);
        probe = 1'b1;
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst_n = 1'b1;

        // Reset state and map boundaries
        probe_pins(1, 64'h0, "reset_gpio_out");
        probe_pins(2, 64'h0, "reset_irq");
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 12; r++)
                rd(12'(b * 64 + r * 4), 32'h0, 1'b0, $sformatf("reset_b%0d_r%0d", b, r));
        rd(12'h080, 32'h0, 1'b1, "bank2_unmapped");
        rd(12'h030, 32'h0, 1'b1, "offset30_unmapped");
        rd(12'hFC4, 32'h0, 1'b1, "global_unmapped");
        rd(12'hFC0, 32'h0, 1'b0, "dbpresc_reset");
        apb(1'b1, 12'h088, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_bank2_unmapped");
        rd(12'h008, 32'h0, 1'b0, "bank0_out_untouched");

        // Atomic output updates
        wr(12'h008, 32'h0000_00F0);
        wr(12'h00C, 32'h0000_0003);
        wr(12'h010, 32'h0000_0010);
        wr(12'h014, 32'h8000_0001);
        probe_pins(1, 64'h0000_0000_8000_00E2, "atomic_out_pins");
        rd(12'h008, 32'h8000_00E2, 1'b0, "out_readback");
        rd(12'h00C, 32'h0, 1'b0, "outset_reads_zero");
        wr(12'h000, 32'hFFFF_0000);
        rd(12'h000, 32'hFFFF_0000, 1'b0, "dir_readback");
        probe_pins(3, 64'h0000_0000_FFFF_0000, "dir_pins");
        wr(12'h048, 32'hA5A5_0000);
        probe_pins(1, 64'hA5A5_0000_8000_00E2, "bank1_out_pins");

        // Rising-edge interrupt on pin 37 and interrupt line timing
        wr(12'h058, 32'h0000_0020);
        wr(12'h060, 32'h0000_0020);
        gpio_in[37] = 1'b1;
        idle(2);
        probe_pins(2, 64'h0, "irq_during_sync");
        probe_pins(2, 64'h0, "irq_on_stat_edge");
        probe_pins(2, 64'h2, "irq1_asserted");
        rd(12'h068, 32'h0000_0020, 1'b0, "intstat1_rise");
        rd(12'h044, 32'h0000_0020, 1'b0, "in1_pin37");
        wr(12'h068, 32'h0000_0020);
        probe_pins(2, 64'h2, "irq1_register_lag");
        probe_pins(2, 64'h0, "irq1_cleared");
        rd(12'h068, 32'h0, 1'b0, "intstat1_cleared");

        // Any-edge on pin 0, second set coincides with W1C
        wr(12'h024, 32'h0000_0001);
        wr(12'h018, 32'h0000_0001);
        gpio_in[0] = 1'b1;
        idle(1);
        wr(12'h028, 32'h0000_0001);
        rd(12'h028, 32'h0, 1'b0, "anyedge_rise_cleared");
        idle(3);
        gpio_in[0] = 1'b0;
        wr(12'h028, 32'h0000_0001);
        rd(12'h028, 32'h0000_0001, 1'b0, "set_beats_w1c");
        wr(12'h028, 32'h0000_0001);
        rd(12'h028, 32'h0, 1'b0, "anyedge_final_clear");

        // Debounce on pin 3 with a 4-cycle prescaler
        wr(12'h02C, 32'h0000_0008);
        wr(12'hFC0, 32'h0000_0003);
        rd(12'hFC0, 32'h0000_0003, 1'b0, "dbpresc_readback");
        gpio_in[3] = 1'b1;
        idle(6);
        gpio_in[3] = 1'b0;
        idle(4);
        rd(12'h004, 32'h0, 1'b0, "db_glitch_rejected");
        gpio_in[3] = 1'b1;
        idle(12);
        rd(12'h004, 32'h0, 1'b0, "db_three_ticks");
        idle(1);
        rd(12'h004, 32'h0000_0008, 1'b0, "db_accepted");

        // Level-0 on pin 7 re-sets after W1C while the level persists
        wr(12'h01C, 32'h0000_0080);
        wr(12'h018, 32'h0000_0080);
        rd(12'h028, 32'h0000_0080, 1'b0, "lev0_set");
        wr(12'h028, 32'h0000_0080);
        rd(12'h028, 32'h0000_0080, 1'b0, "lev0_reset_after_w1c");
        probe_pins(2, 64'h1, "irq0_lev0");

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        probe_pins(1, 64'h0, "async_reset_out");
        probe_pins(2, 64'h0, "async_reset_irq");
        probe_pins(3, 64'h0, "async_reset_dir");
        rst_n = 1'b1;
        rd(12'h028, 32'h0, 1'b0, "post_reset_intstat0");
        rd(12'h02C, 32'h0, 1'b0, "post_reset_dben0");
        rd(12'hFC0, 32'h0, 1'b0, "post_reset_dbpresc");
        rd(12'h004, 32'h0000_0008, 1'b0, "post_reset_in0");
        rd(12'h044, 32'h0000_0020, 1'b0, "post_reset_in1");

        idle(2);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
